joybus_tx: RTL and testbench



---
 rtl/joybus_pkg.sv | 28 ++
 rtl/joybus_tx_bit_timer.sv | 41 ++++
 rtl/joybus_tx.sv | 142 ++++++++++++++
 tb/tb_joybus_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/joybus_pkg.sv
// Shared JOYBUS transmitter types and constants: FSM state encoding, default
// bit timing for a 25 MHz clock, and the common console command words.
package joybus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BIT_LOW   = 3'd1,
        ST_BIT_HIGH  = 3'd2,
        ST_STOP_LOW  = 3'd3,
        ST_STOP_HIGH = 3'd4,
        ST_DONE      = 3'd5,
        ST_GUARD     = 3'd6
    } joybus_tx_state_t;

    localparam int Q_CYCLES_DEF   = 25;
    localparam int BIT_CYCLES_DEF = 100;

    localparam logic [7:0]  CMD_N64_STATUS = 8'h00;
    localparam logic [7:0]  CMD_N64_POLL   = 8'h01;
    localparam logic [23:0] CMD_GC_POLL    = 24'h400300;
    localparam logic [7:0]  CMD_GC_PROBE   = 8'h00;

    // States in which the line is actively pulled low.
    function automatic logic drives_low(input joybus_tx_state_t s);
        return (s == ST_BIT_LOW) || (s == ST_STOP_LOW);
    endfunction

endpackage

// File: rtl/joybus_tx_bit_timer.sv
// Phase timer for one JOYBUS bit cell: counts the low or high phase of the
// current bit and flags its last cycle. The stop bit reuses it with bit_val=1.
module joybus_tx_bit_timer #(
    parameter int Q_CYCLES   = 25,
    parameter int BIT_CYCLES = 100,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bit_val,
    input  logic stop,
    input  logic high_phase,
    output logic phase_end,
    output logic bit_end
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] phase_len;

    always_comb begin
        low_len   = bit_val ? CNT_W'(Q_CYCLES) : CNT_W'(BIT_CYCLES - Q_CYCLES);
        phase_len = low_len;
        if (high_phase) begin
            // The stop bit's high phase is shortened to two quarters.
            phase_len = stop ? CNT_W'(2 * Q_CYCLES) : (CNT_W'(BIT_CYCLES) - low_len);
        end
        phase_end = (cnt == (phase_len - CNT_W'(1)));
        bit_end   = high_phase && phase_end;
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/joybus_tx.sv
// Console-side JOYBUS command transmitter (MSB first, plus console stop bit).
// Optional post-frame guard gap enabled by defining JOYBUS_TX_GUARD_EN.
module joybus_tx
    import joybus_pkg::*;
#(
    parameter int Q_CYCLES     = Q_CYCLES_DEF,
    parameter int BIT_CYCLES   = BIT_CYCLES_DEF,
    parameter int MAX_BITS     = 24,
    parameter int GUARD_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_start,
    input  logic [MAX_BITS-1:0] tx_data,
    input  logic [4:0]          tx_len,
    output logic                JB_TX_OE,
    output logic                tx_busy,
    output logic                tx_done,
    output joybus_tx_state_t    dbg_state
);

    localparam int         CNT_W   = $clog2(BIT_CYCLES);
    localparam logic [4:0] MAX_LEN = 5'(MAX_BITS);

    if (BIT_CYCLES != 4 * Q_CYCLES || Q_CYCLES < 1 || GUARD_CYCLES < 1) begin : g_bad_params
        $error("joybus_tx: need BIT_CYCLES == 4*Q_CYCLES, Q_CYCLES >= 1, GUARD_CYCLES >= 1");
    end

    joybus_tx_state_t    state;
    joybus_tx_state_t    state_next;
    logic [MAX_BITS-1:0] shreg;
    logic [4:0]          bit_cnt;
    logic [4:0]          len_clamped;
    logic                timing;
    logic                stop;
    logic                high_phase;
    logic                timer_load;
    logic                timer_bit;
    logic                phase_end;
    logic                bit_end;

    // Handshake: tx_start is a request sampled only while tx_busy is low; a
    // start seen with tx_busy high is dropped, never queued.
    assign len_clamped = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;

    assign timing     = (state == ST_BIT_LOW) || (state == ST_BIT_HIGH) ||
                        (state == ST_STOP_LOW) || (state == ST_STOP_HIGH);
    assign stop       = (state == ST_STOP_LOW) || (state == ST_STOP_HIGH);
    assign high_phase = (state == ST_BIT_HIGH) || (state == ST_STOP_HIGH);
    assign timer_load = (state_next != state) || !timing;
    assign timer_bit  = stop | shreg[MAX_BITS-1];

    joybus_tx_bit_timer #(
        .Q_CYCLES  (Q_CYCLES),
        .BIT_CYCLES(BIT_CYCLES),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .bit_val   (timer_bit),
        .stop      (stop),
        .high_phase(high_phase),
        .phase_end (phase_end),
        .bit_end   (bit_end)
    );

`ifdef JOYBUS_TX_GUARD_EN
    localparam int GW = $clog2(GUARD_CYCLES) + 1;
    logic [GW-1:0] guard_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_GUARD) begin
            guard_cnt <= '0;
        end else begin
            guard_cnt <= guard_cnt + GW'(1);
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_next = (len_clamped == 5'd0) ? ST_STOP_LOW : ST_BIT_LOW;
                end
            end
            ST_BIT_LOW: begin
                if (phase_end) state_next = ST_BIT_HIGH;
            end
            ST_BIT_HIGH: begin
                if (bit_end) state_next = (bit_cnt > 5'd1) ? ST_BIT_LOW : ST_STOP_LOW;
            end
            ST_STOP_LOW: begin
                if (phase_end) state_next = ST_STOP_HIGH;
            end
            ST_STOP_HIGH: begin
                if (phase_end) state_next = ST_DONE;
            end
            ST_DONE: begin
`ifdef JOYBUS_TX_GUARD_EN
                state_next = ST_GUARD;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_GUARD: begin
`ifdef JOYBUS_TX_GUARD_EN
                if (guard_cnt == GW'(GUARD_CYCLES - 1)) state_next = ST_IDLE;
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            JB_TX_OE <= 1'b0;
        end else begin
            state    <= state_next;
            JB_TX_OE <= drives_low(state_next);
            if (state == ST_IDLE && tx_start) begin
                shreg   <= tx_data;
                bit_cnt <= len_clamped;
            end else if (state == ST_BIT_HIGH && bit_end) begin
                shreg   <= {shreg[MAX_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end
        end
    end

    assign tx_busy   = (state != ST_IDLE);
    assign tx_done   = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_joybus_tx.sv
// Self-checking bench for joybus_tx: frames are compared against a waveform
// model built from the JOYBUS bit rules (1 = 1us low, 0 = 3us low, stop bit).
module tb_joybus_tx;
    import joybus_pkg::*;

    logic             clk;
    logic             rst;
    logic             tx_start;
    logic [23:0]      tx_data;
    logic [4:0]       tx_len;
    logic             JB_TX_OE;
    logic             tx_busy;
    logic             tx_done;
    joybus_tx_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [0:0] exp_q[$];
    logic       obs_oe[$];
    int         done_at;
    int         waited;
    bit         busy_drop;

`ifdef JOYBUS_TX_GUARD_EN
    localparam logic BUSY_AFTER = 1'b1;
`else
    localparam logic BUSY_AFTER = 1'b0;
`endif

    joybus_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_len   (tx_len),
        .JB_TX_OE (JB_TX_OE),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per bit, a 1 is 25 cycles low then 75 released, a 0 is 75
    // low then 25 released; the stop bit is 25 low then 50 released.
    function automatic void model_frame(input logic [23:0] d, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int low = d[23 - i] ? 25 : 75;
            for (int c = 0; c < 100; c++) exp_q.push_back((c < low) ? 1'b1 : 1'b0);
        end
        for (int c = 0; c < 75; c++) exp_q.push_back((c < 25) ? 1'b1 : 1'b0);
    endfunction

    function automatic int first_diff();
        int n = (obs_oe.size() < exp_q.size()) ? obs_oe.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_oe[i] !== exp_q[i][0]) return i;
        if (obs_oe.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int clamp_len(input logic [4:0] l);
        return (int'(l) > 24) ? 24 : int'(l);
    endfunction

    // Called just after a negedge. Waits for idle, pulses tx_start, and
    // records OE each cycle until tx_done (bounded).
    task automatic capture_frame(input logic [23:0] d, input logic [4:0] l, input bit spam);
        waited = 0;
        while (tx_busy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        obs_oe.delete();
        done_at   = -1;
        busy_drop = 0;
        tx_data   = d;
        tx_len    = l;
        tx_start  = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (tx_done) begin
                done_at = k;
                break;
            end
            obs_oe.push_back(JB_TX_OE);
            if (!tx_busy) busy_drop = 1;
            if (spam) begin
                tx_data = 24'($urandom);
                tx_len  = 5'($urandom);
            end else begin
                tx_start = 1'b0;
            end
        end
        tx_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = '0;
        tx_len = '0;
        repeat (3) @(negedge clk);
        checks++; if (JB_TX_OE !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", JB_TX_OE); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", tx_done); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_n64_status();
        int diff;
        capture_frame({CMD_N64_STATUS, 16'h0000}, 5'd8, 1'b0);
        model_frame({CMD_N64_STATUS, 16'h0000}, 8);
        diff = first_diff();
        checks++; if (diff != -1) begin errors++; $display("FAIL n64_wave first diff at %0d (got %0d samples want %0d)", diff, obs_oe.size(), exp_q.size()); end
        checks++; if (done_at != 876) begin errors++; $display("FAIL n64_done_cycle got %0d want 876", done_at); end
        @(negedge clk);
        checks++; if (tx_busy !== BUSY_AFTER || tx_done !== 1'b0) begin errors++; $display("FAIL n64_after busy=%b done=%b want busy=%b done=0", tx_busy, tx_done, BUSY_AFTER); end
    endtask

    task automatic test_gc_poll();
        int diff;
        int i;
        logic [23:0] rec;
        capture_frame(CMD_GC_POLL, 5'd24, 1'b0);
        model_frame(CMD_GC_POLL, 24);
        diff = first_diff();
        checks++; if (diff != -1) begin errors++; $display("FAIL gc_wave first diff at %0d (got %0d samples want %0d)", diff, obs_oe.size(), exp_q.size()); end
        checks++; if (done_at != 2476) begin errors++; $display("FAIL gc_done_cycle got %0d want 2476", done_at); end
        checks++; if (busy_drop) begin errors++; $display("FAIL gc_busy got busy low mid-frame want high throughout"); end
        // Decode the line: a short low pulse is a 1, a long one is a 0.
        rec = '0;
        i = 0;
        for (int b = 0; b < 24; b++) begin
            int run = 0;
            while (i < obs_oe.size() && obs_oe[i] === 1'b1) begin run++; i++; end
            while (i < obs_oe.size() && obs_oe[i] === 1'b0) i++;
            rec = {rec[22:0], (run > 0 && run < 50) ? 1'b1 : 1'b0};
        end
        checks++; if (rec !== 24'h400300) begin errors++; $display("FAIL gc_decode got %h want 400300", rec); end
    endtask

    task automatic test_start_spam();
        int diff;
        logic [23:0] d = 24'($urandom);
        logic [4:0]  l = 5'($urandom_range(1, 24));
        capture_frame(d, l, 1'b1);
        model_frame(d, clamp_len(l));
        diff = first_diff();
        checks++; if (diff != -1) begin errors++; $display("FAIL spam_wave first diff at %0d (got %0d samples want %0d)", diff, obs_oe.size(), exp_q.size()); end
        checks++; if (done_at != clamp_len(l) * 100 + 76) begin errors++; $display("FAIL spam_done_cycle got %0d want %0d", done_at, clamp_len(l) * 100 + 76); end
        @(negedge clk);
        checks++; if (tx_busy !== BUSY_AFTER) begin errors++; $display("FAIL spam_single_frame busy=%b want %b", tx_busy, BUSY_AFTER); end
    endtask

    task automatic test_reset_mid_frame();
        int diff;
        bit saw_done = 0;
        bit saw_oe = 0;
        logic [23:0] d = 24'($urandom);
        int n = 0;
        while (tx_busy && n < 1000) begin @(negedge clk); n++; end
        tx_data = 24'($urandom);
        tx_len = 5'd24;
        tx_start = 1'b1;
        for (int k = 1; k <= 149; k++) begin
            @(negedge clk);
            tx_start = 1'b0;
        end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before got %b want 1", tx_busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (JB_TX_OE !== 1'b0 || tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_next oe=%b busy=%b want 0 0", JB_TX_OE, tx_busy); end
        repeat (300) begin
            @(negedge clk);
            if (tx_done) saw_done = 1;
            if (JB_TX_OE) saw_oe = 1;
        end
        checks++; if (saw_done || saw_oe) begin errors++; $display("FAIL midreset_quiet done_seen=%b oe_seen=%b want 0 0", saw_done, saw_oe); end
        capture_frame(d, 5'd24, 1'b0);
        model_frame(d, 24);
        diff = first_diff();
        checks++; if (diff != -1 || done_at != 2476) begin errors++; $display("FAIL midreset_refire diff=%0d done=%0d want -1 2476", diff, done_at); end
    endtask

    task automatic test_len_edges();
        int diff;
        logic [23:0] d = 24'($urandom);
        capture_frame(d, 5'd0, 1'b0);
        model_frame(d, 0);
        diff = first_diff();
        checks++; if (diff != -1) begin errors++; $display("FAIL len0_wave first diff at %0d (got %0d want %0d)", diff, obs_oe.size(), exp_q.size()); end
        checks++; if (done_at != 76) begin errors++; $display("FAIL len0_done_cycle got %0d want 76", done_at); end
        d = 24'($urandom);
        capture_frame(d, 5'd31, 1'b0);
        model_frame(d, 24);
        diff = first_diff();
        checks++; if (diff != -1) begin errors++; $display("FAIL len31_wave first diff at %0d (got %0d want %0d)", diff, obs_oe.size(), exp_q.size()); end
        checks++; if (done_at != 2476) begin errors++; $display("FAIL len31_done_cycle got %0d want 2476", done_at); end
    endtask

    task automatic test_back_to_back();
        int diff;
        logic [23:0] d = 24'($urandom);
        logic [4:0]  l = 5'($urandom_range(1, 8));
        capture_frame({CMD_N64_POLL, 16'h0000}, 5'd8, 1'b0);
        @(negedge clk);
`ifdef JOYBUS_TX_GUARD_EN
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL guard_busy got %b want 1", tx_busy); end
        tx_data = 24'hFFFFFF;
        tx_len = 5'd8;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        checks++; if (JB_TX_OE !== 1'b0 || dbg_state !== ST_GUARD) begin errors++; $display("FAIL guard_ignore oe=%b state=%0d want 0 %0d", JB_TX_OE, dbg_state, ST_GUARD); end
        repeat (198) @(negedge clk);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL guard_len_200 busy=%b want 1", tx_busy); end
        @(negedge clk);
`endif
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b want 0", tx_busy); end
        capture_frame(d, l, 1'b0);
        model_frame(d, int'(l));
        diff = first_diff();
        checks++; if (waited != 0 || diff != -1) begin errors++; $display("FAIL b2b_accept waited=%0d diff=%0d want 0 -1", waited, diff); end
        checks++; if (done_at != int'(l) * 100 + 76) begin errors++; $display("FAIL b2b_done_cycle got %0d want %0d", done_at, int'(l) * 100 + 76); end
    endtask

    task automatic test_random();
        int diff;
        for (int t = 0; t < 5; t++) begin
            logic [23:0] d = 24'($urandom);
            logic [4:0]  l = 5'($urandom_range(0, 31));
            capture_frame(d, l, 1'b0);
            model_frame(d, clamp_len(l));
            diff = first_diff();
            checks++; if (diff != -1 || done_at != clamp_len(l) * 100 + 76) begin
                errors++;
                $display("FAIL rand_frame d=%h len=%0d diff=%0d done=%0d want -1 %0d", d, l, diff, done_at, clamp_len(l) * 100 + 76);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_start = 1'b0;
        tx_data = '0;
        tx_len = '0;
        @(negedge clk);
        test_reset();
        test_n64_status();
        test_gc_poll();
        test_start_spam();
        test_reset_mid_frame();
        test_len_edges();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
